// File: rtl/wb_arb2_ctrl_pkg.sv
// wb_arb2_ctrl_pkg: shared state/grant encodings and width helper for the
// two-master Wishbone arbiter and its outstanding-strobe counter.
package wb_arb2_ctrl_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_GNT0,
        ARB_GNT1,
        ARB_DRN0,
        ARB_DRN1
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/wb_outstanding_ctr.sv
// wb_outstanding_ctr: up/down count of accepted-but-unanswered strobes,
// saturating at 0 and MAXOUT; cnt_next exposes the post-update value.
module wb_outstanding_ctr
    import wb_arb2_ctrl_pkg::*;
#(
    parameter int MAXOUT = 16,
    parameter int CW     = clog2(MAXOUT + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] cnt,
    output logic [CW-1:0] cnt_next,
    output logic          full
);

    localparam logic [CW-1:0] MAX = CW'(MAXOUT);

    assign full = (cnt == MAX);

    always_comb begin
        cnt_next = (inc && !dec && !full)         ? cnt + 1'b1 :
                   (dec && !inc && cnt != '0)     ? cnt - 1'b1 : cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= cnt_next;
    end

endmodule

// File: rtl/wb_arb2_ctrl.sv
// wb_arb2_ctrl: two-master to one-slave pipelined Wishbone arbiter; holds the
// grant for a whole master cycle including the drain of outstanding acks.
module wb_arb2_ctrl
    import wb_arb2_ctrl_pkg::*;
#(
    parameter int ADDRBITS = 26,
    parameter int DATABITS = 16,
    parameter int MAXOUT   = 16,
    parameter bit RR       = 1'b1
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    input  logic                m0_cyc_i,
    input  logic                m0_stb_i,
    input  logic                m0_we_i,
    input  logic [ADDRBITS-1:0] m0_adr_i,
    input  logic [DATABITS-1:0] m0_dat_i,
    output logic                m0_ack_o,
    output logic                m0_err_o,
    output logic                m0_stall_o,
    output logic [DATABITS-1:0] m0_dat_o,
    input  logic                m1_cyc_i,
    input  logic                m1_stb_i,
    input  logic                m1_we_i,
    input  logic [ADDRBITS-1:0] m1_adr_i,
    input  logic [DATABITS-1:0] m1_dat_i,
    output logic                m1_ack_o,
    output logic                m1_err_o,
    output logic                m1_stall_o,
    output logic [DATABITS-1:0] m1_dat_o,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    output logic                s_we_o,
    output logic [ADDRBITS-1:0] s_adr_o,
    output logic [DATABITS-1:0] s_dat_o,
    input  logic                s_ack_i,
    input  logic                s_err_i,
    input  logic                s_stall_i,
    input  logic [DATABITS-1:0] s_dat_i,
    output logic [1:0]          grant_o,
    output logic                busy_o
);

    localparam int CW = clog2(MAXOUT + 1);

    arb_state_t    state, state_next;
    logic          last_m1, last_m1_next;
    logic          own0, own1, gnt, drn, full;
    logic          o_cyc, o_stb;
    logic [CW-1:0] cnt, cnt_next;

    assign own0  = (state == ARB_GNT0) || (state == ARB_DRN0);
    assign own1  = (state == ARB_GNT1) || (state == ARB_DRN1);
    assign gnt   = (state == ARB_GNT0) || (state == ARB_GNT1);
    assign drn   = (state == ARB_DRN0) || (state == ARB_DRN1);
    assign o_cyc = own1 ? m1_cyc_i : m0_cyc_i;
    assign o_stb = own1 ? m1_stb_i : m0_stb_i;

    assign s_cyc_o = drn || (gnt && o_cyc);
    assign s_stb_o = gnt && o_stb && !full;
    assign s_we_o  = own1 ? m1_we_i  : m0_we_i;
    assign s_adr_o = own1 ? m1_adr_i : m0_adr_i;
    assign s_dat_o = own1 ? m1_dat_i : m0_dat_i;

    assign m0_ack_o   = own0 && s_ack_i;
    assign m0_err_o   = own0 && s_err_i;
    assign m1_ack_o   = own1 && s_ack_i;
    assign m1_err_o   = own1 && s_err_i;
    assign m0_stall_o = (state != ARB_GNT0) || s_stall_i || full;
    assign m1_stall_o = (state != ARB_GNT1) || s_stall_i || full;
    assign m0_dat_o   = s_dat_i;
    assign m1_dat_o   = s_dat_i;

    assign grant_o = own0 ? GRANT_M0 : own1 ? GRANT_M1 : GRANT_NONE;
    assign busy_o  = (state != ARB_IDLE);

    wb_outstanding_ctr #(.MAXOUT(MAXOUT), .CW(CW)) u_ctr (
        .clk      (clk_i),
        .rst_n    (reset_ni),
        .inc      (s_stb_o && !s_stall_i),
        .dec      (s_ack_i || s_err_i),
        .cnt      (cnt),
        .cnt_next (cnt_next),
        .full     (full)
    );

    // On exit the other master takes over if it is waiting; otherwise the
    // current master may resume if it re-raised cyc during the drain.
    always_comb begin
        state_next   = state;
        last_m1_next = last_m1;
        case (state)
            ARB_IDLE: begin
                if (m0_cyc_i && (!m1_cyc_i || !RR || last_m1)) state_next = ARB_GNT0;
                else if (m1_cyc_i)                             state_next = ARB_GNT1;
            end
            ARB_GNT0, ARB_DRN0: begin
                if ((drn || !m0_cyc_i) && cnt_next == '0) begin
                    state_next   = m1_cyc_i ? ARB_GNT1 : m0_cyc_i ? ARB_GNT0 : ARB_IDLE;
                    last_m1_next = 1'b0;
                end else if (!m0_cyc_i || drn) begin
                    state_next = ARB_DRN0;
                end
            end
            ARB_GNT1, ARB_DRN1: begin
                if ((drn || !m1_cyc_i) && cnt_next == '0) begin
                    state_next   = m0_cyc_i ? ARB_GNT0 : m1_cyc_i ? ARB_GNT1 : ARB_IDLE;
                    last_m1_next = 1'b1;
                end else if (!m1_cyc_i || drn) begin
                    state_next = ARB_DRN1;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state   <= ARB_IDLE;
            last_m1 <= 1'b1;
        end else begin
            state   <= state_next;
            last_m1 <= last_m1_next;
        end
    end

endmodule

// File: doc/wb_arb2_ctrl.md
Name: wb_arb2_ctrl

Overview:
- Two-master to one-slave arbiter and sequencer for the pipelined Wishbone port that drives the flash-side datapath.
- m0 is the QSPI bridge control FSM. m1 is a background requester, such as the VT sweep or scrub engine.
- Grant is held for a whole master cycle. The grant is kept through the drain of outstanding acks, because the bridge drops cyc on its first ack while further acks are still in flight.
- Only one master owns the slave at any time.

Parameters:
- ADDRBITS, 26, Wishbone address width.
- DATABITS, 16, Wishbone data width.
- MAXOUT, 16, maximum outstanding (accepted, un-acked) strobes.
- RR, 1, selects the arbitration scheme: 1 = round-robin on contention, 0 = m0 fixed priority.

Ports:
- clk_i  in  1  system clock
- reset_ni  in  1  reset, asynchronous, active-low
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 cycle / strobe / write
- m0_adr_i  in  ADDRBITS  master 0 address
- m0_dat_i  in  DATABITS  master 0 write data
- m0_ack_o, m0_err_o, m0_stall_o  out  1 each  master 0 responses
- m0_dat_o  out  DATABITS  read data (equals s_dat_i)
- m1_*: same set as m0_*, for master 1
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave cycle / strobe / write
- s_adr_o  out  ADDRBITS  slave address
- s_dat_o  out  DATABITS  slave write data
- s_ack_i, s_err_i, s_stall_i  in  1 each  slave responses
- s_dat_i  in  DATABITS  slave read data
- grant_o  out  2  one-hot owner; 00 = none
- busy_o  out  1  high when state is not IDLE

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (reset_ni). Asserting reset_ni low immediately forces:
  - state = IDLE, grant_o = 00, outstanding count = 0, last-served = m1, so m0 wins the first tie.
  - Outputs: s_cyc_o = s_stb_o = 0; m*_ack_o = m*_err_o = 0; m*_stall_o = 1.
  - In-flight acks are lost; the masters own recovery.
- States: IDLE, GNT0, GNT1, DRN0, DRN1. The state is registered; all slave-side outputs are a combinational mux of the owner's inputs.
- Outstanding count:
  - +1 on s_stb_o && !s_stall_i; -1 on s_ack_i || s_err_i; both in the same cycle leaves it unchanged.
  - Counter width is clog2(MAXOUT+1).
  - cnt_next is the post-update value and is used for all transitions below.
- IDLE:
  - Only m0_cyc_i high -> GNT0. Only m1_cyc_i high -> GNT1.
  - Both high: RR=1 grants the master not last-served; RR=0 grants m0.
  - One-cycle grant latency: cyc seen in cycle N, the first strobe can be accepted in cycle N+1.
- GNTx:
  - s_cyc_o = mx_cyc_i, s_stb_o = mx_stb_i; we/adr/dat come from mx.
  - mx_stall_o = s_stall_i || (cnt == MAXOUT). In the MAXOUT case, s_stb_o is also forced 0.
  - mx_cyc_i low with cnt_next > 0 -> DRNx.
  - mx_cyc_i low with cnt_next == 0 -> handover: GNTy if my_cyc_i is high, else IDLE. last-served = x.
- DRNx:
  - s_cyc_o = 1, s_stb_o = 0, mx_stall_o = 1.
  - s_ack_i / s_err_i are still routed to mx.
  - Exit on cnt_next == 0 using the same handover rule as GNTx.
  - mx re-raising cyc during DRNx stays stalled; DRNx goes back to GNTx only if mx is the winner at exit.
- Response routing:
  - The owner is the master of the current GNTx or DRNx state.
  - m*_ack_o and m*_err_o are asserted only for the owner; responses are never routed to the non-owner.
  - m0_dat_o and m1_dat_o both equal s_dat_i.
  - The non-owner's stall is held at 1, so it holds its strobe.
- Error cases:
  - An ack or err arriving in IDLE is dropped, and the counter does not underflow (saturates at 0).
- Handover timing: the new owner's first strobe may appear on the slave in the cycle right after the old owner's last ack. There is no dead cycle.
- Fairness: with both masters streaming continuously, RR=1 alternates ownership at each master's cycle boundary.

Decomposition:
- Shared package holds:
  - state encoding localparams (ARB_IDLE, ARB_GNT0, ARB_GNT1, ARB_DRN0, ARB_DRN1);
  - grant encodings;
  - the clog2 helper for the counter width.
- Sub-module wb_outstanding_ctr:
  - up/down counter with saturation at 0 and MAXOUT;
  - outputs cnt, cnt_next, full.
  - It is also reusable by the bridge's inflight tracking.

Test Plan:
- Single read, m0 only: m0_cyc/stb in cycle 0, slave acks with no stall in cycle 2 -> grant_o = 01 in cycle 1; s_stb_o = 1 in cycle 1 only; m0_ack_o in cycle 2; state returns to IDLE one cycle after cyc drops.
- Drain, bridge-style: m0 issues 4 pipelined reads, drops cyc on the first ack, slave acks at 1-cycle spacing -> state DRN0; s_cyc_o held high; all 4 acks reach m0; IDLE when cnt = 0.
- Contention, RR=1: m0 and m1 raise cyc in the same cycle from reset -> m0 granted first; m1_stall_o = 1 until m0's last ack; GNT1 with no dead cycle; on the next simultaneous request m0 wins again.
- Backpressure: MAXOUT = 4, m1 streams 8 strobes while the slave withholds acks -> exactly 4 accepted; m1_stall_o = 1 and s_stb_o = 0 until the first ack; the 5th strobe is accepted the cycle after.
- Slave stall and err: s_stall_i high for 3 cycles -> m0_stall_o mirrors it, the count is unchanged, the address is held. Then s_err_i on the 2nd response -> only m0_err_o pulses, and the count decrements.
- Reset mid-drain: reset_ni low in DRN0 with cnt = 3 -> outputs reach reset values asynchronously; a stray s_ack_i after release produces no master ack; the count stays 0.
